// File: rtl/run_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// run_pkg : shared run-controller state encoding and bus widths
// Revision: 1.0
// ---------------------------------------------------------------------------
package run_pkg;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;
    localparam int CW_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CORE_RST = 2'd1,
        RUN      = 2'd2,
        DONE     = 2'd3
    } run_state_t;

endpackage
`default_nettype wire

// File: rtl/run_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// run_ctrl_if : core, host, data-memory and status signals of the run controller
// Revision: 1.0
// ---------------------------------------------------------------------------
interface run_ctrl_if
    import run_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) ();

    logic              start;
    logic              abort;
    logic              core_done;
    logic              core_en;
    logic              core_reset;
    logic              core_wr_en;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              finished;
    logic              timed_out;
    logic [CW-1:0]     cycle_cnt;

    modport slave (
        input  start, abort, core_done, core_wr_en, core_addr, core_wdata,
               host_req, host_we, host_addr, host_wdata, mem_rdata,
        output core_en, core_reset, core_rdata, host_gnt, host_rvalid, host_rdata,
               mem_wr_en, mem_addr, mem_wdata, busy, finished, timed_out, cycle_cnt
    );

    modport master (
        output start, abort, core_done, core_wr_en, core_addr, core_wdata,
               host_req, host_we, host_addr, host_wdata, mem_rdata,
        input  core_en, core_reset, core_rdata, host_gnt, host_rvalid, host_rdata,
               mem_wr_en, mem_addr, mem_wdata, busy, finished, timed_out, cycle_cnt
    );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_counter : up-counter with synchronous clear that sticks at all-ones
// Revision: 1.0
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         clear,
    input  wire logic         enable,
    output logic [W-1:0]      count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/run_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// run_ctrl : launches/stops core program runs and arbitrates data memory with a host
// Revision: 1.0
// ---------------------------------------------------------------------------
module run_ctrl
    import run_pkg::*;
#(
    parameter int            CW      = CW_DEFAULT,
    parameter logic [CW-1:0] TIMEOUT = 16'd4000
) (
    input  wire logic clk,
    input  wire logic reset,
    run_ctrl_if.slave bus
);

    run_state_t    r_state;
    run_state_t    w_next;
    logic          r_timed_out;
    logic          r_host_rvalid;
    logic [DATA_W-1:0] r_host_rdata;
    logic [CW-1:0] w_cnt;
    logic          w_in_run;
    logic          w_host_side;
    logic          w_timeout;
    logic          w_core_en;
    logic          w_gnt;
    logic          w_cnt_clr;

    assign w_in_run    = (r_state == RUN);
    assign w_host_side = (r_state == IDLE) || (r_state == DONE);
    assign w_timeout   = (w_cnt == TIMEOUT - 1'b1);
    assign w_cnt_clr   = (r_state == CORE_RST);

    // Gating with reset keeps the core frozen and blocks any memory write in the reset cycle.
    assign w_core_en = w_in_run && !reset;
    assign w_gnt     = bus.host_req && w_host_side && !reset;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (bus.start) w_next = CORE_RST;
            CORE_RST: w_next = RUN;
            RUN:      if (bus.core_done || bus.abort || w_timeout) w_next = DONE;
            DONE:     if (bus.start) w_next = CORE_RST;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Only a timeout with neither core_done nor abort present counts as timed out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timed_out <= 1'b0;
        end else if (r_state == CORE_RST) begin
            r_timed_out <= 1'b0;
        end else if (w_in_run && w_timeout && !bus.core_done && !bus.abort) begin
            r_timed_out <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= '0;
        end else begin
            r_host_rvalid <= w_gnt && !bus.host_we;
            if (w_gnt && !bus.host_we) begin
                r_host_rdata <= bus.mem_rdata;
            end
        end
    end

    sat_counter #(
        .W      (CW)
    ) u_cycle_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_cnt_clr),
        .enable (w_in_run),
        .count  (w_cnt)
    );

    always_comb begin
        bus.mem_addr  = bus.host_addr;
        bus.mem_wdata = bus.host_wdata;
        bus.mem_wr_en = bus.host_req && bus.host_we && w_gnt;
        if (w_in_run) begin
            bus.mem_addr  = bus.core_addr;
            bus.mem_wdata = bus.core_wdata;
            bus.mem_wr_en = bus.core_wr_en && w_core_en;
        end
    end

    assign bus.core_rdata  = bus.mem_rdata;
    assign bus.core_en     = w_core_en;
    assign bus.core_reset  = (r_state == IDLE) || (r_state == CORE_RST);
    assign bus.host_gnt    = w_gnt;
    assign bus.host_rvalid = r_host_rvalid;
    assign bus.host_rdata  = r_host_rdata;
    assign bus.busy        = (r_state == CORE_RST) || w_in_run;
    assign bus.finished    = (r_state == DONE);
    assign bus.timed_out   = r_timed_out;
    assign bus.cycle_cnt   = w_cnt;

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_run_ctrl : directed bench; instance a uses the default TIMEOUT, instance b TIMEOUT=20
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_run_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    run_ctrl_if #(.CW(16)) bus_a ();
    run_ctrl_if #(.CW(16)) bus_b ();

    run_ctrl #(.CW(16)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    run_ctrl #(.CW(16), .TIMEOUT(16'd20)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    assign bus_a.mem_rdata = mem_a[bus_a.mem_addr];
    assign bus_b.mem_rdata = mem_b[bus_b.mem_addr];

    always @(posedge clk) begin
        if (bus_a.mem_wr_en) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
        if (bus_b.mem_wr_en) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
    end

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [7:0] a, input logic [7:0] d);
        bus_a.host_req   = 1'b1;
        bus_a.host_we    = 1'b1;
        bus_a.host_addr  = a;
        bus_a.host_wdata = d;
        #1;
        chk("wr_gnt", bus_a.host_gnt, 1);
        chk("wr_mem_we", bus_a.mem_wr_en, 1);
        tick();
    endtask

    task automatic rd_a(input logic [7:0] a, input logic [7:0] exp);
        bus_a.host_req  = 1'b1;
        bus_a.host_we   = 1'b0;
        bus_a.host_addr = a;
        exp_q.push_back(exp);
        #1;
        chk("rd_gnt", bus_a.host_gnt, 1);
        tick();
    endtask

    task automatic rv_a(input string tag);
        chk({tag, "_rvalid"}, bus_a.host_rvalid, 1);
        chk("sb_nonempty", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk({tag, "_rdata"}, bus_a.host_rdata, exp_q.pop_front());
    endtask

    task automatic run_b(input int n, input int done_at, input int abort_at);
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        tick();
        chk("b_cnt_cleared", bus_b.cycle_cnt, 0);
        chk("b_to_cleared", bus_b.timed_out, 0);
        for (int k = 1; k <= n; k++) begin
            bus_b.core_done = (k == done_at);
            bus_b.abort     = (k == abort_at);
            if (k == n) chk("b_busy_last", bus_b.busy, 1);
            tick();
        end
        bus_b.core_done = 1'b0;
        bus_b.abort     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        rst_a = 1'b1;
        rst_b = 1'b1;
        {bus_a.start, bus_a.abort, bus_a.core_done, bus_a.core_wr_en} = '0;
        {bus_a.core_addr, bus_a.core_wdata} = '0;
        {bus_a.host_req, bus_a.host_we, bus_a.host_addr, bus_a.host_wdata} = '0;
        {bus_b.start, bus_b.abort, bus_b.core_done, bus_b.core_wr_en} = '0;
        {bus_b.core_addr, bus_b.core_wdata} = '0;
        {bus_b.host_req, bus_b.host_we, bus_b.host_addr, bus_b.host_wdata} = '0;
        tick();
        tick();

        chk("rst_core_en", bus_a.core_en, 0);
        chk("rst_core_reset", bus_a.core_reset, 1);
        chk("rst_busy", bus_a.busy, 0);
        chk("rst_finished", bus_a.finished, 0);
        chk("rst_cnt", bus_a.cycle_cnt, 0);
        chk("rst_timed_out", bus_a.timed_out, 0);
        chk("rst_rvalid", bus_a.host_rvalid, 0);
        chk("rst_rdata", bus_a.host_rdata, 0);
        rst_a = 1'b0;

        bus_a.abort = 1'b1;
        tick();
        bus_a.abort = 1'b0;
        chk("idle_abort_busy", bus_a.busy, 0);
        chk("idle_abort_core_reset", bus_a.core_reset, 1);

        // Host write then read in IDLE
        wr_a(8'h10, 8'h5A);
        rd_a(8'h10, 8'h5A);
        bus_a.host_req = 1'b0;
        rv_a("rd_5a");
        tick();
        chk("rvalid_one_cycle", bus_a.host_rvalid, 0);

        // Back-to-back accesses
        wr_a(8'h30, 8'h21);
        wr_a(8'h31, 8'h22);
        rd_a(8'h30, 8'h21);
        rv_a("b2b_rd0");
        rd_a(8'h31, 8'h22);
        rv_a("b2b_rd1");
        bus_a.host_req = 1'b0;
        tick();
        chk("b2b_rvalid_end", bus_a.host_rvalid, 0);

        // Normal run ended by core_done on RUN cycle 37
        bus_a.core_addr  = 8'h40;
        bus_a.core_wdata = 8'hC3;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        chk("crst_core_reset", bus_a.core_reset, 1);
        chk("crst_core_en", bus_a.core_en, 0);
        chk("crst_busy", bus_a.busy, 1);
        tick();
        chk("run_core_reset", bus_a.core_reset, 0);
        chk("run_core_en", bus_a.core_en, 1);
        chk("run_cnt_start", bus_a.cycle_cnt, 0);
        errs = 0;
        for (int k = 1; k <= 37; k++) begin
            bus_a.core_wr_en = (k == 10);
            bus_a.core_done  = (k == 37);
            #1;
            if (k == 10) chk("core_store_we", bus_a.mem_wr_en, 1);
            if (k == 12) chk("core_rdata", bus_a.core_rdata, 8'hC3);
            if (bus_a.core_en !== 1'b1 || bus_a.core_reset !== 1'b0 || bus_a.busy !== 1'b1) errs++;
            tick();
        end
        bus_a.core_wr_en = 1'b0;
        bus_a.core_done  = 1'b0;
        chk("run_flags", errs, 0);
        chk("done_finished", bus_a.finished, 1);
        chk("done_busy", bus_a.busy, 0);
        chk("done_core_en", bus_a.core_en, 0);
        chk("done_core_reset", bus_a.core_reset, 0);
        chk("done_cnt", bus_a.cycle_cnt, 37);
        chk("done_timed_out", bus_a.timed_out, 0);
        rd_a(8'h40, 8'hC3);
        bus_a.host_req = 1'b0;
        rv_a("rd_core_store");

        bus_a.abort = 1'b1;
        tick();
        bus_a.abort = 1'b0;
        chk("done_abort_ignored", bus_a.finished, 1);

        // start with a host write in DONE, then host request held across the run
        bus_a.host_req   = 1'b1;
        bus_a.host_we    = 1'b1;
        bus_a.host_addr  = 8'h50;
        bus_a.host_wdata = 8'h77;
        bus_a.start      = 1'b1;
        #1;
        chk("start_gnt", bus_a.host_gnt, 1);
        tick();
        bus_a.start      = 1'b0;
        bus_a.host_addr  = 8'h51;
        bus_a.host_wdata = 8'hEE;
        chk("hold_crst_busy", bus_a.busy, 1);
        errs = 0;
        for (int k = 0; k <= 5; k++) begin
            bus_a.core_done = (k == 5);
            bus_a.start     = (k == 2);
            #1;
            if (bus_a.host_gnt !== 1'b0 || bus_a.mem_wr_en !== 1'b0) errs++;
            if (k >= 1 && bus_a.core_en !== 1'b1) errs++;
            tick();
        end
        bus_a.core_done = 1'b0;
        bus_a.start     = 1'b0;
        #1;
        chk("hold_no_gnt", errs, 0);
        chk("hold_first_gnt", bus_a.host_gnt, 1);
        chk("hold_first_we", bus_a.mem_wr_en, 1);
        chk("hold_finished", bus_a.finished, 1);
        chk("hold_cnt", bus_a.cycle_cnt, 5);
        tick();
        rd_a(8'h50, 8'h77);
        rv_a("rd_start_wr");
        rd_a(8'h51, 8'hEE);
        bus_a.host_req = 1'b0;
        rv_a("rd_held_wr");

        // Reset on RUN cycle 10 while the core stores
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        tick();
        for (int k = 1; k < 10; k++) tick();
        bus_a.core_addr  = 8'h60;
        bus_a.core_wdata = 8'h99;
        bus_a.core_wr_en = 1'b1;
        rst_a = 1'b1;
        #1;
        chk("rst_run_mem_we", bus_a.mem_wr_en, 0);
        tick();
        rst_a = 1'b0;
        bus_a.core_wr_en = 1'b0;
        chk("rrst_core_en", bus_a.core_en, 0);
        chk("rrst_core_reset", bus_a.core_reset, 1);
        chk("rrst_busy", bus_a.busy, 0);
        chk("rrst_finished", bus_a.finished, 0);
        chk("rrst_cnt", bus_a.cycle_cnt, 0);
        chk("rrst_timed_out", bus_a.timed_out, 0);
        chk("rrst_rvalid", bus_a.host_rvalid, 0);
        chk("rrst_rdata", bus_a.host_rdata, 0);
        chk("rrst_no_store", (mem_a[8'h60] === 8'h99), 0);

        // Instance b: TIMEOUT = 20
        rst_b = 1'b0;
        run_b(20, 0, 0);
        chk("to_finished", bus_b.finished, 1);
        chk("to_cnt", bus_b.cycle_cnt, 20);
        chk("to_timed_out", bus_b.timed_out, 1);

        run_b(20, 20, 0);
        chk("done_at_to_finished", bus_b.finished, 1);
        chk("done_at_to_cnt", bus_b.cycle_cnt, 20);
        chk("done_at_to_timed_out", bus_b.timed_out, 0);

        run_b(5, 0, 5);
        chk("abort_finished", bus_b.finished, 1);
        chk("abort_cnt", bus_b.cycle_cnt, 5);
        chk("abort_timed_out", bus_b.timed_out, 0);

        run_b(3, 3, 3);
        chk("abort_done_finished", bus_b.finished, 1);
        chk("abort_done_cnt", bus_b.cycle_cnt, 3);
        chk("abort_done_timed_out", bus_b.timed_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- CW, 16, cycle-counter width.
- TIMEOUT, 16'd4000, maximum RUN cycles before forced stop.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and reset.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, single-cycle pulse that launches a program run.
- abort, in, 1, single-cycle pulse that cancels a run.
- core_done, in, 1, done flag from the processor core.
- core_en, out, 1, core advance enable (PC, register file and flags update only when high).
- core_reset, out, 1, reset sent to the core.
- core_wr_en, in, 1, core store strobe.
- core_addr, in, 8, core memory address.
- core_wdata, in, 8, core store data.
- core_rdata, out, 8, load data returned to the core.
- host_req, in, 1, host memory-access request, level.
- host_we, in, 1, host write (1) or read (0).
- host_addr, in, 8, host memory address.
- host_wdata, in, 8, host write data.
- host_gnt, out, 1, host access performed this cycle.
- host_rvalid, out, 1, host read data valid.
- host_rdata, out, 8, registered host read data.
- mem_wr_en, out, 1, data-memory write enable.
- mem_addr, out, 8, data-memory address.
- mem_wdata, out, 8, data-memory write data.
- mem_rdata, in, 8, data-memory combinational read data.
- busy, out, 1, high in CORE_RST and RUN.
- finished, out, 1, high in DONE.
- timed_out, out, 1, last run hit TIMEOUT.
- cycle_cnt, out, CW, RUN cycles in the current or last run.

Function
REQ-004 The FSM shall have four states (IDLE, CORE_RST, RUN, DONE) held in a registered state variable.
REQ-005 IDLE shall go to CORE_RST on start; otherwise it stays in IDLE.
REQ-006 CORE_RST shall last exactly one cycle and then go to RUN.
REQ-007 RUN shall go to DONE on core_done, on cycle_cnt == TIMEOUT-1, or on abort.
REQ-008 DONE shall go to CORE_RST on start; otherwise it stays in DONE.
REQ-009 core_reset shall be 1 in IDLE and CORE_RST and 0 otherwise.
REQ-010 core_en shall be 1 only in RUN; the core is frozen, not reset, in DONE so its state stays inspectable.
REQ-011 The memory mux shall work as follows:
- In RUN, mem_* comes from the core, and mem_wr_en = core_wr_en & core_en.
- In all other states, mem_* comes from the host, and mem_wr_en = host_req & host_we & host_gnt.
- core_rdata = mem_rdata at all times.
REQ-012 host_gnt shall equal host_req while the state is IDLE or DONE, and 0 in CORE_RST and RUN (the host stalls holding its request).
REQ-013 A host write shall commit at the clock edge ending the gnt cycle.
REQ-014 A host read shall capture mem_rdata into host_rdata at that same edge, and host_rvalid shall be 1 for exactly the next cycle.
REQ-015 With host_req held, the host shall get one access per cycle, so back-to-back reads give rvalid on consecutive cycles.
REQ-016 The cycle counter shall behave as follows:
- It clears to 0 in CORE_RST.
- It increments by 1 each RUN cycle.
- It holds in IDLE and DONE.
- It saturates at all-ones and never wraps.
REQ-017 timed_out shall be set on the RUN->DONE transition caused solely by the timeout, and cleared in CORE_RST.
REQ-018 If core_done and the timeout condition occur in the same cycle, core_done shall win and timed_out stays 0.
REQ-019 abort in RUN shall go to DONE with timed_out = 0; abort in any other state shall be ignored.
REQ-020 If abort and core_done coincide, the result shall be DONE with timed_out = 0.
REQ-021 start shall be ignored in CORE_RST and RUN.
REQ-022 If start and host_req coincide in IDLE or DONE, the host access shall still be granted in that cycle and the state advances at the same edge.

Reset
REQ-023 On reset, the block shall enter IDLE, with cycle_cnt = 0, timed_out = 0, host_rvalid = 0 and host_rdata = 0.
REQ-024 Reset mid-run shall abandon the run immediately, with no memory write in the reset cycle.
REQ-025 Outputs after reset shall be: core_en = 0, core_reset = 1, busy = 0, finished = 0.

Structure
REQ-026 A shared package run_pkg shall hold the run_state_t enum (IDLE, CORE_RST, RUN, DONE), the address and data width constants (8) and the CW default.
REQ-027 The saturating counter shall be one sub-module, sat_counter, with clear, enable and count ports.
REQ-028 The memory mux shall be inline combinational logic, not a separate module.

Verification
REQ-029 Host write 0x5A to addr 0x10 in IDLE, then read addr 0x10: host_gnt = 1 on each request, and host_rvalid with host_rdata = 0x5A one cycle after the read gnt.
REQ-030 start, core_done asserted on the 37th RUN cycle: exactly one core_reset-only cycle (CORE_RST) then RUN; finished = 1; cycle_cnt = 37; timed_out = 0; a host read in DONE returns the core's stored value.
REQ-031 TIMEOUT = 20, core_done never asserted: DONE after 20 RUN cycles, cycle_cnt = 20, timed_out = 1; a new start clears both.
REQ-032 host_req held during RUN: host_gnt = 0 throughout; the first gnt appears in the first DONE cycle; no host write reaches memory during RUN.
REQ-033 core_done coincident with the timeout cycle: timed_out = 0; then abort at RUN cycle 5 of the next run: DONE, cycle_cnt = 5.
REQ-034 reset asserted at RUN cycle 10 while core_wr_en = 1: IDLE next cycle, mem_wr_en = 0 in the reset cycle, all outputs at their REQ-023 and REQ-025 values.
